// File: rtl/vm_multi_item_pkg.sv
// Shared types and constants for the multi-item vending controller.
package vm_multi_item_pkg;

    localparam int unsigned NUM_STATES   = 7;
    localparam int unsigned IDLE_IDX     = 0;
    localparam int unsigned CHECK_IDX    = 1;
    localparam int unsigned COLLECT_IDX  = 2;
    localparam int unsigned EVAL_IDX     = 3;
    localparam int unsigned DISPENSE_IDX = 4;
    localparam int unsigned REFUND_IDX   = 5;
    localparam int unsigned RESTOCK_IDX  = 6;

    typedef enum logic [NUM_STATES-1:0] {
        S_IDLE     = NUM_STATES'(1 << IDLE_IDX),
        S_CHECK    = NUM_STATES'(1 << CHECK_IDX),
        S_COLLECT  = NUM_STATES'(1 << COLLECT_IDX),
        S_EVAL     = NUM_STATES'(1 << EVAL_IDX),
        S_DISPENSE = NUM_STATES'(1 << DISPENSE_IDX),
        S_REFUND   = NUM_STATES'(1 << REFUND_IDX),
        S_RESTOCK  = NUM_STATES'(1 << RESTOCK_IDX)
    } fsm_state_t;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'b00,
        ST_AVAILABLE    = 2'b01,
        ST_OUT_OF_STOCK = 2'b10,
        ST_ERROR        = 2'b11
    } status_t;

    localparam int unsigned NICKEL_C  = 5;
    localparam int unsigned DIME_C    = 10;
    localparam int unsigned QUARTER_C = 25;

    // Coin code to value in cents.
    function automatic int unsigned coin_value(input logic [1:0] coin);
        case (coin)
            2'b01:   return NICKEL_C;
            2'b10:   return DIME_C;
            2'b11:   return QUARTER_C;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/vm_multi_item_watchdog.sv
// Loadable down-counter; expire_c pulses when an enabled count reaches zero.
module vm_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 512
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || reload) begin
            cnt_q <= CNT_W'(TIMEOUT_CYC - 1);
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign expire_c = en && !reload && (cnt_q == '0);

endmodule

// File: rtl/vm_multi_item.sv
// Multi-item vending controller with restock port, change/refund and watchdog.
// Define VM_AUTO_REFUND_EN to refund (rather than forfeit) the amount on timeout.
module vm_multi_item
    import vm_multi_item_pkg::*;
#(
    parameter int unsigned NUM_ITEMS   = 8,
    parameter int unsigned COUNT_W     = 4,
    parameter int unsigned COST_W      = 8,
    parameter int unsigned BAL_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 512,
    localparam int unsigned ITEM_W     = $clog2(NUM_ITEMS)
) (
    input  logic              clk,
    input  logic              hrst,
    input  logic              srst,
    input  logic [1:0]        coins,
    input  logic              btn_valid,
    input  logic [ITEM_W-1:0] buttons,
    input  logic              select,
    input  logic              cancel,
    input  logic              valid,
    input  logic [ITEM_W-1:0] item,
    input  logic [COUNT_W-1:0] count,
    input  logic [COST_W-1:0] cost,
    output logic [ITEM_W-1:0] product,
    output logic              product_valid,
    output logic [1:0]        status,
    output logic [BAL_W-1:0]  balance,
    output logic              change_valid,
    output logic [COST_W-1:0] info
);

    localparam int unsigned MAX_STOCK = 2**COUNT_W - 1;

    fsm_state_t         state_q, state_d;
    logic [BAL_W-1:0]   amount_q, amount_d;
    logic [ITEM_W-1:0]  sel_q, sel_d;
    logic               restock_done_q, restock_done_d;
    logic [COUNT_W-1:0] stock_q [NUM_ITEMS];
    logic [COST_W-1:0]  price_q [NUM_ITEMS];

    logic               stock_we, price_we;
    logic [ITEM_W-1:0]  stock_idx;
    logic [COUNT_W-1:0] stock_wd;
    logic [BAL_W:0]     coin_sum;
    logic [COUNT_W:0]   restock_sum;
    logic [BAL_W-1:0]   price_ext;

    logic [ITEM_W-1:0]  product_d;
    logic               product_valid_d, change_valid_d;
    status_t            status_d;
    logic [BAL_W-1:0]   balance_d;
    logic [COST_W-1:0]  info_d;
    logic               expire_c;

    vm_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
        .clk      (clk),
        .rst      (hrst),
        .reload   (!state_q[COLLECT_IDX] || (coins != 2'b00)),
        .en       (state_q[COLLECT_IDX]),
        .expire_c (expire_c)
    );

    // Next-state, datapath enables and next output values.
    always_comb begin
        state_d         = state_q;
        amount_d        = amount_q;
        sel_d           = sel_q;
        restock_done_d  = 1'b0;
        stock_we        = 1'b0;
        price_we        = 1'b0;
        stock_idx       = sel_q;
        stock_wd        = stock_q[sel_q];
        product_d       = '0;
        product_valid_d = 1'b0;
        status_d        = ST_IDLE;
        balance_d       = '0;
        change_valid_d  = 1'b0;
        coin_sum        = {1'b0, amount_q} + (BAL_W+1)'(coin_value(coins));
        restock_sum     = {1'b0, stock_q[item]} + {1'b0, count};
        price_ext       = BAL_W'(price_q[sel_q]);

        unique case (1'b1)
            state_q[IDLE_IDX]: begin
                if (valid) begin
                    state_d = S_RESTOCK;
                end else if (btn_valid) begin
                    if ({1'b0, buttons} >= (ITEM_W+1)'(NUM_ITEMS)) begin
                        status_d = ST_ERROR;
                    end else begin
                        sel_d   = buttons;
                        state_d = S_CHECK;
                    end
                end
            end
            state_q[CHECK_IDX]: begin
                if (stock_q[sel_q] != '0) begin
                    status_d = ST_AVAILABLE;
                    state_d  = S_COLLECT;
                end else begin
                    status_d = ST_OUT_OF_STOCK;
                    state_d  = S_IDLE;
                end
            end
            state_q[COLLECT_IDX]: begin
                status_d = ST_AVAILABLE;
                if (coin_sum[BAL_W]) begin
                    amount_d = '1;
                    status_d = ST_ERROR;
                end else begin
                    amount_d = coin_sum[BAL_W-1:0];
                end
                if (cancel) begin
                    state_d = S_REFUND;
                end else if (select) begin
                    state_d = S_EVAL;
                end else if (expire_c) begin
`ifdef VM_AUTO_REFUND_EN
                    state_d = S_REFUND;
`else
                    state_d  = S_IDLE;
                    amount_d = '0;
                    status_d = ST_ERROR;
`endif
                end
            end
            state_q[EVAL_IDX]: begin
                if (amount_q >= price_ext) begin
                    product_d       = sel_q;
                    product_valid_d = 1'b1;
                    balance_d       = amount_q - price_ext;
                    change_valid_d  = (balance_d != '0);
                    state_d         = S_DISPENSE;
                end else begin
                    status_d = ST_AVAILABLE;
                    state_d  = S_COLLECT;
                end
            end
            state_q[DISPENSE_IDX]: begin
                stock_we = 1'b1;
                stock_wd = stock_q[sel_q] - COUNT_W'(1);
                amount_d = '0;
                state_d  = S_IDLE;
            end
            state_q[REFUND_IDX]: begin
                balance_d      = amount_q;
                change_valid_d = (amount_q != '0);
                amount_d       = '0;
                state_d        = S_IDLE;
            end
            state_q[RESTOCK_IDX]: begin
                restock_done_d = 1'b1;
                // Only the first cycle of a supplier session applies the update.
                if (!restock_done_q) begin
                    if (restock_sum > (COUNT_W+1)'(MAX_STOCK)) begin
                        status_d = ST_ERROR;
                    end else begin
                        stock_we  = 1'b1;
                        stock_idx = item;
                        stock_wd  = restock_sum[COUNT_W-1:0];
                    end
                    price_we = (cost != '0);
                end
                if (!valid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Soft reset abandons the transaction but never touches the tables.
        if (srst) begin
            state_d = ((state_q[COLLECT_IDX] || state_q[EVAL_IDX]) && (amount_q != '0))
                      ? S_REFUND : S_IDLE;
            amount_d        = (state_d == S_REFUND) ? amount_q : '0;
            restock_done_d  = 1'b0;
            stock_we        = 1'b0;
            price_we        = 1'b0;
            product_d       = '0;
            product_valid_d = 1'b0;
            status_d        = ST_IDLE;
            balance_d       = '0;
            change_valid_d  = 1'b0;
        end

        info_d = ((state_d == S_CHECK) || (state_d == S_COLLECT)) ? price_q[sel_d] : '0;
    end

    // State, tables and registered outputs.
    always_ff @(posedge clk) begin
        if (hrst) begin
            state_q        <= S_IDLE;
            amount_q       <= '0;
            sel_q          <= '0;
            restock_done_q <= 1'b0;
            product        <= '0;
            product_valid  <= 1'b0;
            status         <= ST_IDLE;
            balance        <= '0;
            change_valid   <= 1'b0;
            info           <= '0;
            for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= '0;
                price_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            amount_q       <= amount_d;
            sel_q          <= sel_d;
            restock_done_q <= restock_done_d;
            product        <= product_d;
            product_valid  <= product_valid_d;
            status         <= status_d;
            balance        <= balance_d;
            change_valid   <= change_valid_d;
            info           <= info_d;
            if (stock_we) stock_q[stock_idx] <= stock_wd;
            if (price_we) price_q[item]      <= cost;
        end
    end

endmodule

// File: tb/tb_vm_multi_item.sv
// Self-checking bench for vm_multi_item against a transaction-level model.
module tb_vm_multi_item;

    localparam int NI   = 8;
    localparam int MAXS = 15;
    localparam int MAXB = 65535;
    localparam int TO   = 512;

    logic        clk = 1'b0;
    logic        hrst, srst, btn_valid, select, cancel, valid;
    logic [1:0]  coins;
    logic [2:0]  buttons, item;
    logic [3:0]  count;
    logic [7:0]  cost;
    logic [2:0]  product;
    logic        product_valid, change_valid;
    logic [1:0]  status;
    logic [15:0] balance;
    logic [7:0]  info;

    int checks = 0;
    int fails  = 0;
    int m_stock [NI];
    int m_price [NI];
    int m_amount;

    always #5 clk = ~clk;

    vm_multi_item dut (
        .clk(clk), .hrst(hrst), .srst(srst), .coins(coins),
        .btn_valid(btn_valid), .buttons(buttons), .select(select), .cancel(cancel),
        .valid(valid), .item(item), .count(count), .cost(cost),
        .product(product), .product_valid(product_valid), .status(status),
        .balance(balance), .change_valid(change_valid), .info(info)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int coin_val(input logic [1:0] c);
        case (c)
            2'b01:   return 5;
            2'b10:   return 10;
            2'b11:   return 25;
            default: return 0;
        endcase
    endfunction

    function automatic int sat_add(input int a, input int b);
        return (a + b > MAXB) ? MAXB : a + b;
    endfunction

    task automatic request(input int idx, output bit avail);
        btn_valid = 1'b1;
        buttons   = 3'(idx);
        step();
        btn_valid = 1'b0;
        checks++;
        if (info !== 8'(m_price[idx])) begin
            fails++;
            $display("FAIL req_info item %0d: got %0d expected %0d", idx, info, m_price[idx]);
        end
        step();
        avail = (m_stock[idx] != 0);
        checks++;
        if (status !== (avail ? 2'b01 : 2'b10)) begin
            fails++;
            $display("FAIL req_status item %0d: got %b expected %b", idx, status, avail ? 2'b01 : 2'b10);
        end
        m_amount = 0;
    endtask

    task automatic insert(input logic [1:0] c);
        coins = c;
        step();
        coins = 2'b00;
        m_amount = sat_add(m_amount, coin_val(c));
    endtask

    task automatic do_select(input int idx, input logic [1:0] c, output bit disp);
        int ch;
        select = 1'b1;
        coins  = c;
        step();
        select = 1'b0;
        coins  = 2'b00;
        m_amount = sat_add(m_amount, coin_val(c));
        checks++;
        if (product_valid !== 1'b0) begin
            fails++;
            $display("FAIL sel_early_pv: got %b expected 0", product_valid);
        end
        step();
        disp = (m_amount >= m_price[idx]);
        if (disp) begin
            ch = m_amount - m_price[idx];
            checks++;
            if (product_valid !== 1'b1 || product !== 3'(idx)) begin
                fails++;
                $display("FAIL dispense: got pv=%b product=%0d expected pv=1 product=%0d", product_valid, product, idx);
            end
            checks++;
            if (change_valid !== (ch != 0) || balance !== 16'(ch)) begin
                fails++;
                $display("FAIL change: got cv=%b balance=%0d expected cv=%b balance=%0d", change_valid, balance, ch != 0, ch);
            end
            m_stock[idx]--;
            m_amount = 0;
            step();
        end else begin
            checks++;
            if (product_valid !== 1'b0 || status !== 2'b01) begin
                fails++;
                $display("FAIL short_amount: got pv=%b status=%b expected pv=0 status=01", product_valid, status);
            end
        end
    endtask

    task automatic do_cancel(input logic [1:0] c);
        cancel = 1'b1;
        coins  = c;
        step();
        cancel = 1'b0;
        coins  = 2'b00;
        m_amount = sat_add(m_amount, coin_val(c));
        checks++;
        if (change_valid !== 1'b0) begin
            fails++;
            $display("FAIL cancel_early_cv: got %b expected 0", change_valid);
        end
        step();
        checks++;
        if (change_valid !== (m_amount != 0) || balance !== 16'(m_amount)) begin
            fails++;
            $display("FAIL refund: got cv=%b balance=%0d expected cv=%b balance=%0d", change_valid, balance, m_amount != 0, m_amount);
        end
        m_amount = 0;
    endtask

    task automatic restock(input int it, input int cnt, input int cst, input int hold);
        int  errs = 0;
        bit  exp_err;
        valid = 1'b1;
        item  = 3'(it);
        count = 4'(cnt);
        cost  = 8'(cst);
        for (int i = 0; i < hold; i++) begin
            step();
            if (status === 2'b11) errs++;
            else if (status !== 2'b00) errs += 100;
        end
        valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (status === 2'b11) errs++;
            else if (status !== 2'b00) errs += 100;
        end
        exp_err = (m_stock[it] + cnt > MAXS);
        checks++;
        if (errs != (exp_err ? 1 : 0)) begin
            fails++;
            $display("FAIL restock item %0d: got %0d error cycles expected %0d", it, errs, exp_err ? 1 : 0);
        end
        if (!exp_err) m_stock[it] += cnt;
        if (cst != 0) m_price[it] = cst;
    endtask

    task automatic test_reset();
        hrst = 1'b1;
        step();
        step();
        hrst = 1'b0;
        checks++;
        if (product_valid !== 1'b0 || product !== 3'd0) begin
            fails++;
            $display("FAIL reset_product: got pv=%b product=%0d expected 0", product_valid, product);
        end
        checks++;
        if (status !== 2'b00) begin
            fails++;
            $display("FAIL reset_status: got %b expected 00", status);
        end
        checks++;
        if (change_valid !== 1'b0 || balance !== 16'd0) begin
            fails++;
            $display("FAIL reset_change: got cv=%b balance=%0d expected 0", change_valid, balance);
        end
        checks++;
        if (info !== 8'd0) begin
            fails++;
            $display("FAIL reset_info: got %0d expected 0", info);
        end
        for (int i = 0; i < NI; i++) begin
            m_stock[i] = 0;
            m_price[i] = 0;
        end
        m_amount = 0;
    endtask

    task automatic test_purchase();
        bit av, disp;
        restock(3, 5, 60, 2);
        request(3, av);
        for (int i = 0; i < 3; i++) insert(2'b11);
        do_select(3, 2'b00, disp);
    endtask

    task automatic test_retry();
        bit av, disp;
        request(3, av);
        insert(2'b10);
        do_select(3, 2'b00, disp);
        insert(2'b11);
        insert(2'b11);
        do_select(3, 2'b00, disp);
    endtask

    task automatic test_stock_limit();
        bit av, disp;
        restock(1, 10, 0, 1);
        restock(1, 10, 0, 3);
        for (int i = 0; i < 11; i++) begin
            request(1, av);
            if (av) do_select(1, 2'b00, disp);
        end
    endtask

    task automatic test_timeout();
        bit av;
        int early = 0;
        request(3, av);
        insert(2'b01);
        for (int i = 0; i < TO - 1; i++) begin
            step();
            if (change_valid !== 1'b0 || status === 2'b11) early++;
        end
        checks++;
        if (early != 0 || status !== 2'b01) begin
            fails++;
            $display("FAIL timeout_early: got %0d bad cycles status=%b expected 0 and 01", early, status);
        end
        step();
`ifdef VM_AUTO_REFUND_EN
        checks++;
        if (change_valid !== 1'b0) begin
            fails++;
            $display("FAIL timeout_refund_early: got cv=%b expected 0", change_valid);
        end
        step();
        checks++;
        if (change_valid !== 1'b1 || balance !== 16'd5) begin
            fails++;
            $display("FAIL timeout_refund: got cv=%b balance=%0d expected cv=1 balance=5", change_valid, balance);
        end
`else
        checks++;
        if (status !== 2'b11 || change_valid !== 1'b0) begin
            fails++;
            $display("FAIL timeout_abort: got status=%b cv=%b expected 11 and 0", status, change_valid);
        end
        step();
        checks++;
        if (status !== 2'b00 || change_valid !== 1'b0) begin
            fails++;
            $display("FAIL timeout_after: got status=%b cv=%b expected 00 and 0", status, change_valid);
        end
`endif
        m_amount = 0;
    endtask

    task automatic test_srst();
        bit av;
        request(3, av);
        insert(2'b11);
        srst = 1'b1;
        step();
        srst = 1'b0;
        checks++;
        if (change_valid !== 1'b0) begin
            fails++;
            $display("FAIL srst_early_cv: got %b expected 0", change_valid);
        end
        step();
        checks++;
        if (change_valid !== 1'b1 || balance !== 16'd25) begin
            fails++;
            $display("FAIL srst_refund: got cv=%b balance=%0d expected cv=1 balance=25", change_valid, balance);
        end
        m_amount = 0;
        request(3, av);
        do_cancel(2'b00);
        request(5, av);
    endtask

    task automatic test_saturation();
        bit av;
        int errs = 0, exp_errs = 0;
        request(3, av);
        for (int i = 0; i < 2700; i++) begin
            if (m_amount + 25 > MAXB) exp_errs++;
            insert(2'b11);
            if (status === 2'b11) errs++;
        end
        checks++;
        if (errs != exp_errs) begin
            fails++;
            $display("FAIL saturation_status: got %0d error cycles expected %0d", errs, exp_errs);
        end
        do_cancel(2'b00);
    endtask

    task automatic test_random();
        bit av, disp;
        int idx, n;
        for (int r = 0; r < 5; r++)
            restock($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(1, 3));
        for (int t = 0; t < 40; t++) begin
            idx = $urandom_range(0, 7);
            request(idx, av);
            if (!av) continue;
            n = $urandom_range(0, 5);
            for (int k = 0; k < n; k++) insert(2'($urandom_range(1, 3)));
            if ($urandom_range(0, 3) == 0) begin
                do_cancel(2'($urandom_range(0, 3)));
            end else begin
                do_select(idx, 2'($urandom_range(0, 3)), disp);
                if (!disp) do_cancel(2'b00);
            end
        end
    endtask

    initial begin
        hrst = 1'b1; srst = 1'b0; coins = 2'b00; btn_valid = 1'b0; buttons = 3'd0;
        select = 1'b0; cancel = 1'b0; valid = 1'b0; item = 3'd0; count = 4'd0; cost = 8'd0;
        test_reset();
        test_purchase();
        test_retry();
        test_stock_limit();
        test_timeout();
        test_srst();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish within the time limit");
        $fatal(1, "time limit reached");
    end

endmodule
